poly_osc: RTL and testbench

- N-voice polyphonic oscillator driven by decoded MIDI messages: note-on/note-off frames from the MIDI decoder allocate and release voices.
- Per-voice phase accumulators run at a fixed sample rate; voice outputs (saw or square) are mixed into one OUT_W-bit sample.
- Successor to the single-voice, button-gated wave source. sample_dat feeds the SPI DAC path; voice_active can drive LEDs.

---
 rtl/osc_pkg.sv | 22 ++
 rtl/poly_osc_if.sv | 24 ++
 rtl/osc_note_inc.sv | 20 ++
 rtl/poly_osc.sv | 165 ++++++++++++++++
 tb/tb_poly_osc.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/osc_pkg.sv
// rtl/osc_pkg.sv - shared constants, pitch table and FSM state type for poly_osc
package osc_pkg;

  // Phase increments for MIDI notes 120..131 at 50 kHz sample rate, 24-bit phase
  localparam logic [23:0] BASE [0:11] = '{
    24'd2809183, 24'd2976226, 24'd3153201, 24'd3340701,
    24'd3539348, 24'd3749810, 24'd3972785, 24'd4209019,
    24'd4459300, 24'd4724464, 24'd5005395, 24'd5303032
  };

  localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [3:0] NIB_CC       = 4'hB;
  localparam logic [6:0] CC_ALL_OFF   = 7'd123;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUT
  } osc_state_t;

endpackage

// File: rtl/poly_osc_if.sv
// rtl/poly_osc_if.sv - MIDI message input and mixed sample output bundle
interface poly_osc_if #(
  parameter int VOICES = 4,
  parameter int OUT_W  = 8
);
  logic [7:0]        midi_status;
  logic [7:0]        midi_data1;
  logic [7:0]        midi_data2;
  logic              midi_msg_rdy;
  logic              wave_sel;
  logic [OUT_W-1:0]  sample_dat;
  logic              sample_vld;
  logic [VOICES-1:0] voice_active;

  modport master (
    output midi_status, midi_data1, midi_data2, midi_msg_rdy, wave_sel,
    input  sample_dat, sample_vld, voice_active
  );

  modport slave (
    input  midi_status, midi_data1, midi_data2, midi_msg_rdy, wave_sel,
    output sample_dat, sample_vld, voice_active
  );
endinterface

// File: rtl/osc_note_inc.sv
// rtl/osc_note_inc.sv - MIDI note number to phase increment (top-octave table, shifted down)
module osc_note_inc
  import osc_pkg::*;
#(
  parameter int PHASE_W = 24
) (
  input  logic [6:0]         note,
  output logic [PHASE_W-1:0] inc
);
  logic [3:0]  octave;
  logic [3:0]  semi;
  logic [23:0] shifted;

  always_comb begin
    octave  = 4'(note / 7'd12);
    semi    = 4'(note % 7'd12);
    shifted = BASE[semi] >> (4'd10 - octave);
    inc     = PHASE_W'(shifted);
  end
endmodule

// File: rtl/poly_osc.sv
// rtl/poly_osc.sv - MIDI-driven polyphonic saw/square oscillator with voice allocation
// and a sequential per-voice mixer producing one sample every SAMPLE_DIV clocks.
module poly_osc
  import osc_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 8,
  parameter int SAMPLE_DIV = 1000,
  parameter int MIDI_CH    = 0
) (
  input  logic      CLK,
  input  logic      nRST,
  poly_osc_if.slave bus
);
  localparam int VW    = $clog2(VOICES);
  localparam int ACC_W = OUT_W + VW;
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [3:0] CH = 4'(MIDI_CH);

  if (SAMPLE_DIV <= VOICES + 2) begin : g_bad_div
    $error("poly_osc: SAMPLE_DIV must exceed VOICES+2");
  end
  if (VOICES < 2 || VOICES > 16 || (VOICES & (VOICES - 1)) != 0) begin : g_bad_voices
    $error("poly_osc: VOICES must be a power of 2 in 2..16");
  end

  logic [PHASE_W-1:0] phase [VOICES];
  logic [PHASE_W-1:0] inc   [VOICES];
  logic [6:0]         note  [VOICES];
  logic [VOICES-1:0]  active, active_next, hit;
  logic [VW-1:0]      steal_ptr, idx, hit_idx, free_idx, alloc_idx;
  logic [CNT_W-1:0]   tick_cnt;
  logic               tick, wsel, sample_vld_q;
  logic [OUT_W-1:0]   sample_dat_q, contrib;
  logic [ACC_W-1:0]   acc, acc_sum;
  logic [PHASE_W-1:0] new_inc, phase_upd;
  logic [6:0]         key;
  logic               msg_ok, is_on, is_off, is_all_off, hit_any, free_any, alloc_here;
  osc_state_t         state;

  assign bus.sample_dat   = sample_dat_q;
  assign bus.sample_vld   = sample_vld_q;
  assign bus.voice_active = active;

  always_comb begin
    key        = bus.midi_data1[6:0];
    msg_ok     = bus.midi_msg_rdy && !bus.midi_data1[7];
    is_on      = msg_ok && bus.midi_status == {NIB_NOTE_ON, CH} && bus.midi_data2 != 8'd0;
    is_off     = msg_ok && (bus.midi_status == {NIB_NOTE_OFF, CH} ||
                            (bus.midi_status == {NIB_NOTE_ON, CH} && bus.midi_data2 == 8'd0));
    is_all_off = msg_ok && bus.midi_status == {NIB_CC, CH} && key == CC_ALL_OFF;
  end

  // Scan high to low so the lowest matching / free index is the one left standing
  always_comb begin
    hit      = '0;
    hit_any  = 1'b0;
    free_any = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      hit[v] = active[v] && note[v] == key;
      if (hit[v]) begin
        hit_any = 1'b1;
        hit_idx = VW'(v);
      end
      if (!active[v]) begin
        free_any = 1'b1;
        free_idx = VW'(v);
      end
    end
    alloc_idx = hit_any ? hit_idx : (free_any ? free_idx : steal_ptr);
  end

  always_comb begin
    active_next = active;
    if (is_all_off) active_next = '0;
    else if (is_off) active_next = active & ~hit;
    else if (is_on) active_next[alloc_idx] = 1'b1;
  end

  osc_note_inc #(.PHASE_W(PHASE_W)) u_note_inc (
    .note (key),
    .inc  (new_inc)
  );

  // The mixed-in value reflects the voice as it stands after this cycle's MIDI update
  always_comb begin
    alloc_here = is_on && alloc_idx == idx;
    phase_upd  = alloc_here ? '0 : phase[idx] + inc[idx];
    if (!active_next[idx]) contrib = '0;
    else if (wsel) contrib = {OUT_W{phase_upd[PHASE_W-1]}};
    else contrib = phase_upd[PHASE_W-1 -: OUT_W];
    acc_sum = acc + ACC_W'(contrib);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int v = 0; v < VOICES; v++) begin
        phase[v] <= '0;
        inc[v]   <= '0;
        note[v]  <= '0;
      end
      active    <= '0;
      steal_ptr <= '0;
    end else begin
      active <= active_next;
      if (state == ST_ACCUM) phase[idx] <= phase_upd;
      if (is_on) begin
        phase[alloc_idx] <= '0;
        inc[alloc_idx]   <= new_inc;
        note[alloc_idx]  <= key;
        if (!hit_any && !free_any) steal_ptr <= steal_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      idx          <= '0;
      wsel         <= 1'b0;
      acc          <= '0;
      sample_dat_q <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      sample_vld_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            wsel  <= bus.wave_sel;
            acc   <= '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == VW'(VOICES - 1)) begin
            sample_dat_q <= OUT_W'(acc_sum >> VW);
            sample_vld_q <= 1'b1;
            state        <= ST_OUT;
          end
        end
        ST_OUT:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_osc.sv
// tb/tb_poly_osc.sv - self-checking bench for poly_osc against a voice-level reference model
module tb_poly_osc;
  localparam int VOICES     = 4;
  localparam int PHASE_W    = 24;
  localparam int OUT_W      = 8;
  localparam int SAMPLE_DIV = 1000;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #10 CLK = ~CLK;

  poly_osc_if #(.VOICES(VOICES), .OUT_W(OUT_W)) bus ();

  poly_osc #(
    .VOICES(VOICES), .PHASE_W(PHASE_W), .OUT_W(OUT_W),
    .SAMPLE_DIV(SAMPLE_DIV), .MIDI_CH(0)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  longint base_tab [12];
  int     m_note  [VOICES];
  longint m_phase [VOICES];
  longint m_inc   [VOICES];
  bit     m_act   [VOICES];
  int     m_steal;
  int     m_coll;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint note_inc(input int n);
    return base_tab[n % 12] >> (10 - n / 12);
  endfunction

  function automatic void model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_note[v] = 0; m_phase[v] = 0; m_inc[v] = 0; m_act[v] = 0;
    end
    m_steal = 0;
    m_coll  = -1;
  endfunction

  function automatic void model_note_on(input int n);
    int sel = -1;
    for (int v = 0; v < VOICES; v++) if (sel < 0 && m_act[v] && m_note[v] == n) sel = v;
    for (int v = 0; v < VOICES; v++) if (sel < 0 && !m_act[v]) sel = v;
    if (sel < 0) begin
      sel = m_steal;
      m_steal = (m_steal + 1) % VOICES;
    end
    m_note[sel] = n; m_inc[sel] = note_inc(n); m_phase[sel] = 0; m_act[sel] = 1;
  endfunction

  function automatic void model_msg(input bit [7:0] st, input bit [7:0] d1, input bit [7:0] d2);
    if (d1 > 127) return;
    if (st == 8'h90 && d2 != 0) model_note_on(int'(d1));
    else if (st == 8'h80 || (st == 8'h90 && d2 == 0)) begin
      for (int v = 0; v < VOICES; v++) if (m_act[v] && m_note[v] == int'(d1)) m_act[v] = 0;
    end else if (st == 8'hB0 && d1 == 123) begin
      for (int v = 0; v < VOICES; v++) m_act[v] = 0;
    end
  endfunction

  function automatic int model_sample(input bit ws);
    int sum = 0;
    for (int v = 0; v < VOICES; v++) begin
      if (v == m_coll) continue;
      m_phase[v] = (m_phase[v] + m_inc[v]) % (64'd1 << PHASE_W);
      if (m_act[v]) begin
        if (ws) sum += (m_phase[v] >= (64'd1 << (PHASE_W - 1))) ? (2 ** OUT_W - 1) : 0;
        else sum += int'(m_phase[v] / (64'd1 << (PHASE_W - OUT_W)));
      end
    end
    m_coll = -1;
    return sum / VOICES;
  endfunction

  function automatic logic [VOICES-1:0] exp_active();
    logic [VOICES-1:0] a;
    for (int v = 0; v < VOICES; v++) a[v] = m_act[v];
    return a;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_msg(input bit [7:0] st, input bit [7:0] d1, input bit [7:0] d2);
    bus.midi_status = st; bus.midi_data1 = d1; bus.midi_data2 = d2; bus.midi_msg_rdy = 1'b1;
    @(posedge CLK); #1;
    bus.midi_msg_rdy = 1'b0;
    model_msg(st, d1, d2);
    chk("msg_active", 64'(bus.voice_active), 64'(exp_active()));
  endtask

  task automatic wait_sample(input string tag, output int n);
    int exp_v;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!bus.sample_vld && n < 1100);
    chk({tag, "_vld"}, 64'(bus.sample_vld), 64'd1);
    exp_v = model_sample(bus.wave_sel);
    chk(tag, 64'(bus.sample_dat), 64'(exp_v));
    chk({tag, "_act"}, 64'(bus.voice_active), 64'(exp_active()));
  endtask

  task automatic rand_msg(output bit [7:0] st, output bit [7:0] d1, output bit [7:0] d2);
    int kind = $urandom_range(0, 9);
    st = 8'h90; d1 = 8'($urandom_range(36, 96)); d2 = 8'($urandom_range(1, 127));
    case (kind)
      4, 5: begin
        st = 8'h80;
        if (kind == 4) d1 = 8'(m_note[$urandom_range(0, VOICES - 1)]);
      end
      6: begin d1 = 8'(m_note[$urandom_range(0, VOICES - 1)]); d2 = 8'd0; end
      7: begin st = 8'hB0; d1 = 8'd123; d2 = 8'd0; end
      8: st = 8'($urandom_range(0, 1) ? 8'h93 : 8'h81);
      9: begin st = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); end
      default: ;
    endcase
  endtask

  initial begin
    bit [7:0] st, d1, d2;
    for (int k = 0; k < 12; k++) begin
      real f;
      f = 440.0 * (2.0 ** ((51.0 + k) / 12.0));
      base_tab[k] = longint'($rtoi(f * 16777216.0 / 50000.0 + 0.5));
    end
    model_reset();
    bus.midi_status = 8'h00; bus.midi_data1 = 8'h00; bus.midi_data2 = 8'h00;
    bus.midi_msg_rdy = 1'b0; bus.wave_sel = 1'b0;

    idle(3);
    chk("rst_dat", 64'(bus.sample_dat), 64'd0);
    chk("rst_vld", 64'(bus.sample_vld), 64'd0);
    chk("rst_act", 64'(bus.voice_active), 64'd0);
    @(negedge CLK) nRST = 1'b1;
    wait_sample("s_first", cyc);
    chk("first_latency", 64'(cyc), 64'(SAMPLE_DIV + VOICES + 1));
    idle(1);
    chk("vld_pulse", 64'(bus.sample_vld), 64'd0);
    wait_sample("s_idle", cyc);
    chk("period", 64'(cyc), 64'(SAMPLE_DIV - 1));

    idle(10);
    send_msg(8'h90, 8'd69, 8'd100);
    chk("on69_act", 64'(bus.voice_active), 64'b0001);
    chk("on69_inc", 64'(dut.inc[0]), 64'd147639);
    wait_sample("s69_a", cyc);
    wait_sample("s69_b", cyc);
    chk("s69_b_lit", 64'(bus.sample_dat), 64'd1);

    idle(10);
    send_msg(8'hB0, 8'd123, 8'd0);
    send_msg(8'h90, 8'd60, 8'd90);
    send_msg(8'h90, 8'd64, 8'd90);
    send_msg(8'h90, 8'd67, 8'd90);
    send_msg(8'h90, 8'd72, 8'd90);
    chk("four_act", 64'(bus.voice_active), 64'b1111);
    send_msg(8'h90, 8'd76, 8'd90);
    send_msg(8'h90, 8'd79, 8'd90);
    send_msg(8'h80, 8'd79, 8'd0);
    chk("steal_v1", 64'(bus.voice_active), 64'b1101);
    send_msg(8'h80, 8'd76, 8'd0);
    chk("steal_v0", 64'(bus.voice_active), 64'b1100);
    send_msg(8'h80, 8'd50, 8'd0);
    send_msg(8'h93, 8'd60, 8'd90);
    send_msg(8'h90, 8'd200, 8'd90);
    chk("ignored", 64'(bus.voice_active), 64'b1100);
    send_msg(8'h90, 8'd72, 8'd0);
    send_msg(8'h80, 8'd67, 8'd0);
    chk("offs", 64'(bus.voice_active), 64'b0000);
    send_msg(8'h90, 8'd60, 8'd90);
    send_msg(8'h90, 8'd62, 8'd90);
    bus.wave_sel = 1'b1;
    wait_sample("s_sq_a", cyc);
    wait_sample("s_sq_b", cyc);
    idle(5);
    send_msg(8'hB0, 8'd123, 8'd0);
    chk("all_off", 64'(bus.voice_active), 64'd0);

    // Note-on landing exactly on voice 0's accumulate slot
    bus.wave_sel = 1'b0;
    wait_sample("s_pre_coll", cyc);
    repeat (SAMPLE_DIV - VOICES) @(posedge CLK);
    #1;
    bus.midi_status = 8'h90; bus.midi_data1 = 8'd69; bus.midi_data2 = 8'd100;
    bus.midi_msg_rdy = 1'b1;
    @(posedge CLK); #1;
    bus.midi_msg_rdy = 1'b0;
    model_msg(8'h90, 8'd69, 8'd100);
    m_coll = 0;
    chk("coll_act", 64'(bus.voice_active), 64'b0001);
    chk("coll_phase", 64'(dut.phase[0]), 64'd0);
    wait_sample("s_coll_0", cyc);
    wait_sample("s_coll_1", cyc);
    wait_sample("s_coll_2", cyc);

    for (int it = 0; it < 40; it++) begin
      int nmsg = $urandom_range(0, 3);
      idle($urandom_range(5, 50));
      if ($urandom_range(0, 3) == 0) bus.wave_sel = 1'($urandom_range(0, 1));
      for (int m = 0; m < nmsg; m++) begin
        rand_msg(st, d1, d2);
        send_msg(st, d1, d2);
        idle($urandom_range(1, 20));
      end
      wait_sample("s_rnd", cyc);
    end

    idle(5);
    send_msg(8'h90, 8'd70, 8'd100);
    send_msg(8'h90, 8'd75, 8'd100);
    bus.wave_sel = 1'b1;
    wait_sample("s_pre_rst", cyc);
    repeat (SAMPLE_DIV - VOICES + 1) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("mid_rst_dat", 64'(bus.sample_dat), 64'd0);
    chk("mid_rst_vld", 64'(bus.sample_vld), 64'd0);
    chk("mid_rst_act", 64'(bus.voice_active), 64'd0);
    model_reset();
    @(negedge CLK) nRST = 1'b1;
    wait_sample("s_after_rst", cyc);
    chk("rst_latency", 64'(cyc), 64'(SAMPLE_DIV + VOICES + 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
